aucohl_uart_rx: RTL and testbench

- Oversampling serial receiver (UART framing) that sits between the input conditioning stage and the receive FIFO.
- Input `rx` arrives already synchronized and, optionally, glitch-filtered.
- It recovers start, data, optional parity and stop bits using a 16x sample tick.
- Each good character is pushed into the downstream FIFO as a one-cycle `wr` with `wdata`, honouring `full`.

---
 rtl/aucohl_uart_rx_pkg.sv | 23 ++
 rtl/aucohl_uart_rx_ticker.sv | 31 +++
 rtl/aucohl_uart_rx.sv | 164 ++++++++++++++++
 tb/tb_aucohl_uart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/aucohl_uart_rx_pkg.sv
// Shared constants and types for the aucohl UART receiver.
package aucohl_uart_rx_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OVS     = 16;
    localparam int unsigned MID     = 7;
    localparam int unsigned LAST    = OVS - 1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Frame format captured when a start bit is detected
    typedef struct packed {
        logic parity_en;
        logic parity_odd;
    } rx_cfg_t;

endpackage

// File: rtl/aucohl_uart_rx_ticker.sv
// 16x oversample tick generator: one-cycle pulse every clk_div+1 clocks while enabled.
module aucohl_ticker #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] clk_div,
    output logic         tick
);

    logic [W-1:0] cnt;

    // Divisor is compared live; >= recovers cleanly if it shrinks mid-count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= clk_div) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/aucohl_uart_rx.sv
// Oversampling UART receiver: recovers start/data/parity/stop and pushes good characters to a FIFO.
module aucohl_uart_rx
    import aucohl_uart_rx_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          rx,
    input  logic [W-1:0]  clk_div,
    input  logic          parity_en,
    input  logic          parity_odd,
    input  logic          full,
    output logic          wr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic          frame_err,
    output logic          parity_err,
    output logic          overrun_err
);

    localparam int unsigned NW = $clog2(DW + 1);
    localparam int unsigned SW = 4;

    logic          tick;
    rx_state_e     state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [NW-1:0] n_q, n_d;
    logic [DW-1:0] shreg_q, shreg_d;
    rx_cfg_t       cfg_q, cfg_d;
    logic          par_bad_q, par_bad_d;
    logic          wr_d, busy_d, frame_err_d, parity_err_d, overrun_err_d;
    logic [DW-1:0] wdata_d;

    aucohl_ticker #(.W(W)) u_ticker (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clk_div (clk_div),
        .tick    (tick)
    );

    // Next-state, datapath and output pulse decode
    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        n_d           = n_q;
        shreg_d       = shreg_q;
        cfg_d         = cfg_q;
        par_bad_d     = par_bad_q;
        wdata_d       = wdata;
        wr_d          = 1'b0;
        frame_err_d   = 1'b0;
        parity_err_d  = 1'b0;
        overrun_err_d = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            s_d     = '0;
            n_d     = '0;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx) begin
                        state_d   = ST_START;
                        s_d       = '0;
                        cfg_d     = '{parity_en: parity_en, parity_odd: parity_odd};
                        par_bad_d = 1'b0;
                    end
                end
                ST_START: begin
                    if (s_q == SW'(MID)) begin
                        s_d = '0;
                        if (!rx) begin
                            state_d = ST_DATA;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                ST_DATA: begin
                    if (s_q == SW'(LAST)) begin
                        s_d     = '0;
                        shreg_d = {rx, shreg_q[DW-1:1]};
                        n_d     = n_q + NW'(1);
                        if (n_q == NW'(DW - 1)) begin
                            state_d = cfg_q.parity_en ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                ST_PARITY: begin
                    if (s_q == SW'(LAST)) begin
                        s_d       = '0;
                        par_bad_d = (rx != ((^shreg_q) ^ cfg_q.parity_odd));
                        state_d   = ST_STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                ST_STOP: begin
                    if (s_q == SW'(LAST)) begin
                        s_d     = '0;
                        state_d = ST_IDLE;
                        if (!rx) begin
                            frame_err_d = 1'b1;
                        end else if (full) begin
                            overrun_err_d = 1'b1;
                        end else begin
                            wr_d         = 1'b1;
                            wdata_d      = shreg_q;
                            parity_err_d = par_bad_q;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shreg_q     <= '0;
            cfg_q       <= '0;
            par_bad_q   <= 1'b0;
            wr          <= 1'b0;
            wdata       <= '0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shreg_q     <= shreg_d;
            cfg_q       <= cfg_d;
            par_bad_q   <= par_bad_d;
            wr          <= wr_d;
            wdata       <= wdata_d;
            busy        <= busy_d;
            frame_err   <= frame_err_d;
            parity_err  <= parity_err_d;
            overrun_err <= overrun_err_d;
        end
    end

endmodule

// File: tb/tb_aucohl_uart_rx.sv
// Directed, table-driven bench for aucohl_uart_rx (8 data bits).
module tb_aucohl_uart_rx;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          rx = 1'b1;
    logic [W-1:0]  clk_div = '0;
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic          full = 1'b0;
    logic          wr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          frame_err;
    logic          parity_err;
    logic          overrun_err;

    aucohl_uart_rx #(.DW(DW), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rx          (rx),
        .clk_div     (clk_div),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .full        (full),
        .wr          (wr),
        .wdata       (wdata),
        .busy        (busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int wr_cnt, fe_cnt, pe_cnt, ov_cnt, pe_wr_cnt, fe_busy_cnt;
    logic busy_seen;
    logic [7:0] wq[$];

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (wr) begin
            wr_cnt++;
            wq.push_back(wdata);
            if (parity_err) pe_wr_cnt++;
        end
        if (frame_err) begin
            fe_cnt++;
            if (busy) fe_busy_cnt++;
        end
        if (parity_err) pe_cnt++;
        if (overrun_err) ov_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic clear_mon();
        wr_cnt = 0; fe_cnt = 0; pe_cnt = 0; ov_cnt = 0; pe_wr_cnt = 0; fe_busy_cnt = 0;
        busy_seen = 1'b0;
        wq.delete();
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int clks);
        rx = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p_en, input logic p_odd,
                              input logic p_flip, input logic stop_b, input int bclk);
        logic pb;
        pb = (^d) ^ p_odd ^ p_flip;
        drive_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
        if (p_en) drive_bit(pb, bclk);
        drive_bit(stop_b, bclk);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       p_en;
        logic       p_odd;
        logic       p_flip;
        logic       stop_b;
        logic       full;
        int         e_wr;
        int         e_fe;
        int         e_pe;
        int         e_ov;
        logic [7:0] e_wdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vec_t v;
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'hA5};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'h07};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1, 0, 8'h07};
        vecs[3] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'hC3};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 8'hC3};
        vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1, 8'hC3};

        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_wr", int'(wr), 0);
        check("rst_wdata", int'(wdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_parity_err", int'(parity_err), 0);
        check("rst_overrun_err", int'(overrun_err), 0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (10) @(negedge clk);

        // Character table at 16 clocks per bit
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            parity_en = v.p_en;
            parity_odd = v.p_odd;
            full = v.full;
            clear_mon();
            send_frame(v.data, v.p_en, v.p_odd, v.p_flip, v.stop_b, 16);
            repeat (48) @(negedge clk);
            check($sformatf("v%0d_wr", i), wr_cnt, v.e_wr);
            check($sformatf("v%0d_frame_err", i), fe_cnt, v.e_fe);
            check($sformatf("v%0d_parity_err", i), pe_cnt, v.e_pe);
            check($sformatf("v%0d_parity_with_wr", i), pe_wr_cnt, v.e_pe);
            check($sformatf("v%0d_overrun_err", i), ov_cnt, v.e_ov);
            check($sformatf("v%0d_wdata", i), int'(wdata), int'(v.e_wdata));
            check($sformatf("v%0d_busy_idle", i), int'(busy), 0);
            check($sformatf("v%0d_busy_at_frame_err", i), fe_busy_cnt, 0);
        end
        full = 1'b0;
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // False start: low for 4 ticks, rejected at mid start bit
        clear_mon();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("false_start_busy_high", int'(busy), 1);
        repeat (6) @(negedge clk);
        check("false_start_busy_low", int'(busy), 0);
        repeat (30) @(negedge clk);
        check("false_start_wr", wr_cnt, 0);
        check("false_start_pulses", fe_cnt + pe_cnt + ov_cnt, 0);
        check("false_start_busy_seen", int'(busy_seen), 1);

        // Back-to-back frames at clk_div = 3 (64 clocks per bit)
        clk_div = 16'd3;
        clear_mon();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 64);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 64);
        repeat (200) @(negedge clk);
        check("b2b_wr_count", wr_cnt, 2);
        check("b2b_first", wq.size() > 0 ? int'(wq[0]) : -1, 8'h00);
        check("b2b_second", wq.size() > 1 ? int'(wq[1]) : -1, 8'hFF);
        check("b2b_pulses", fe_cnt + pe_cnt + ov_cnt, 0);

        // Async reset in the middle of the data bits of a third frame
        clear_mon();
        drive_bit(1'b0, 64);
        drive_bit(1'b0, 64);
        drive_bit(1'b1, 64);
        drive_bit(1'b0, 30);
        check("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("reset_wr", int'(wr), 0);
        check("reset_wdata", int'(wdata), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_errs", int'(frame_err) + int'(parity_err) + int'(overrun_err), 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("reset_abort_wr", wr_cnt, 0);
        clear_mon();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 64);
        repeat (200) @(negedge clk);
        check("post_reset_wr", wr_cnt, 1);
        check("post_reset_wdata", int'(wdata), 8'h5A);
        check("post_reset_pulses", fe_cnt + pe_cnt + ov_cnt, 0);

        // Dropping en mid-frame returns to idle and holds wdata
        clk_div = 16'd0;
        clear_mon();
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        check("pre_disable_busy", int'(busy), 1);
        en = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("disable_busy", int'(busy), 0);
        en = 1'b1;
        repeat (200) @(negedge clk);
        check("disable_wr", wr_cnt, 0);
        check("disable_pulses", fe_cnt + pe_cnt + ov_cnt, 0);
        check("disable_wdata_held", int'(wdata), 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
